cordic_phase_arbiter: RTL
=========================

Name: cordic_phase_arbiter

Overview:
- Shares one CordicFSM phase engine (24-bit sin/cos in, 27-bit phase out) between NUM_CH demodulator channels.
- Arbitrates round-robin among channels with pending sin/cos samples, sequences the engine's start/done protocol, and returns each phase tagged with its channel index.
- Sits between the lock-in demodulator outputs and the phase post-processing/logging path.
- Includes a watchdog that aborts and resets a hung engine.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16)
- BIT_WIDTH_IN, 24, sin/cos width (signed)
- BIT_WIDTH_OUT, 27, phase width (signed)
- TIMEOUT, 64, max cycles in WAIT before abort (≥ engine latency + 2)

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NUM_CH  channel c has a sample pending
- req_ready_o  out  NUM_CH  one-hot grant; sample of channel c accepted this cycle
- sin_i  in  NUM_CH x BIT_WIDTH_IN  per-channel sine, signed
- cos_i  in  NUM_CH x BIT_WIDTH_IN  per-channel cosine, signed
- cordic_start_o  out  1  start pulse to engine
- cordic_reset_o  out  1  active-high engine reset (abort)
- cordic_sin_o  out  BIT_WIDTH_IN  registered operand to engine
- cordic_cos_o  out  BIT_WIDTH_IN  registered operand to engine
- cordic_phi_i  in  BIT_WIDTH_OUT  engine phase result
- cordic_done_i  in  1  engine result valid
- res_valid_o  out  1  result available
- res_ready_i  in  1  downstream accepts result
- res_phi_o  out  BIT_WIDTH_OUT  phase result, signed
- res_ch_o  out  clog2(NUM_CH)  channel tag of result
- timeout_o  out  1  sticky: a watchdog abort occurred

Behaviour:
- Reset (async assert, sync deassert by the clock domain): state IDLE; all outputs 0; rr pointer 0; timeout_o 0; operand/result registers 0.
- States: IDLE, START, WAIT, OUTPUT, ABORT.
- IDLE:
  - If any req_valid_i, grant the first set bit at or after the rr pointer, searching upward with wrap.
  - req_ready_o[g]=1 for exactly that cycle (combinational from state and req_valid_i).
  - Latch sin_i[g], cos_i[g] and g on that edge → START.
  - No request → stay in IDLE.
- START: cordic_start_o=1 for exactly one cycle; watchdog counter cleared → WAIT.
- WAIT:
  - Counter increments each cycle.
  - First cycle with cordic_done_i=1: latch cordic_phi_i into res_phi_o, set res_ch_o=g → OUTPUT.
  - If the counter reaches TIMEOUT-1 without done → ABORT.
  - If done and timeout occur in the same cycle, done wins.
- OUTPUT:
  - res_valid_o=1; res_phi_o and res_ch_o held stable until res_valid_o & res_ready_i.
  - On that handshake: rr pointer ← g+1 (mod NUM_CH) → IDLE.
  - res_ready_i already high on entry → handshake completes in the first OUTPUT cycle.
- ABORT:
  - cordic_reset_o=1 for one cycle; timeout_o←1 (cleared only by reset_ni); rr pointer ← g+1 → IDLE.
  - No result is produced; the aborted sample is dropped.
- cordic_sin_o/cordic_cos_o are driven from the operand registers, stable from START until the next grant.
- cordic_done_i is ignored outside WAIT. The engine may hold done high as a level; the FSM never restarts on a stale done because START always precedes WAIT.
- Latency: grant → res_valid_o = 2 + engine latency cycles. Minimum per-sample period = 3 + engine latency + output stall cycles.
- Fairness: a continuously requesting channel waits at most NUM_CH-1 completed jobs.
- req_valid_i deasserting while ungranted is legal; no state is kept for ungranted channels.
- res_ch_o width is clog2(NUM_CH), minimum 1.

Test Plan:
- Single request: ch2 valid, sin=0, cos=4194304 → one-cycle req_ready_o=0b0100, one start pulse, res_phi_o=0, res_ch_o=2, res_valid_o held until res_ready_i.
- Round-robin: all 4 channels held valid with distinct operands (ch1 sin=4194304, cos=0 → phi=13176793) → grant order 0,1,2,3,0; every result tag matches its operands.
- Backpressure: res_ready_i low for 10 cycles → res_valid_o, res_phi_o, res_ch_o stable; no further grant or start during the stall.
- Watchdog: stub engine never raises done → after TIMEOUT cycles in WAIT, one cordic_reset_o pulse, timeout_o=1 stays set, next channel granted, no res_valid_o.
- Done on last cycle: done raised exactly at counter TIMEOUT-1 → result delivered, timeout_o stays 0.
- Mid-operation reset: reset_ni low during WAIT → all outputs 0 immediately; after release, idle until a new request; a late done_i is ignored.

Source files
------------

// File: rtl/cordic_phase_arbiter.sv
// Round-robin front end that time-shares a single CORDIC phase engine between
// NUM_CH demodulator channels, with a watchdog that aborts a hung engine.
module cordic_phase_arbiter #(
    parameter int NUM_CH        = 4,
    parameter int BIT_WIDTH_IN  = 24,
    parameter int BIT_WIDTH_OUT = 27,
    parameter int TIMEOUT       = 64,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                                    clk_i,
    input  logic                                    reset_ni,
    input  logic [NUM_CH-1:0]                       req_valid_i,
    output logic [NUM_CH-1:0]                       req_ready_o,
    input  logic [NUM_CH-1:0][BIT_WIDTH_IN-1:0]     sin_i,
    input  logic [NUM_CH-1:0][BIT_WIDTH_IN-1:0]     cos_i,
    output logic                                    cordic_start_o,
    output logic                                    cordic_reset_o,
    output logic [BIT_WIDTH_IN-1:0]                 cordic_sin_o,
    output logic [BIT_WIDTH_IN-1:0]                 cordic_cos_o,
    input  logic [BIT_WIDTH_OUT-1:0]                cordic_phi_i,
    input  logic                                    cordic_done_i,
    output logic                                    res_valid_o,
    input  logic                                    res_ready_i,
    output logic [BIT_WIDTH_OUT-1:0]                res_phi_o,
    output logic [CH_W-1:0]                         res_ch_o,
    output logic                                    timeout_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_OUTPUT = 3'd3,
        ST_ABORT  = 3'd4
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;
    logic [CH_W-1:0]          rr_ptr_r;
    logic [CH_W-1:0]          grant_ch_r;
    logic [CNT_W-1:0]         wdog_cnt_r;
    logic [BIT_WIDTH_IN-1:0]  op_sin_r;
    logic [BIT_WIDTH_IN-1:0]  op_cos_r;
    logic [BIT_WIDTH_OUT-1:0] res_phi_r;
    logic [CH_W-1:0]          res_ch_r;
    logic                     start_r;
    logic                     abort_r;
    logic                     res_valid_r;
    logic                     timeout_r;

    logic [2*NUM_CH-1:0]      req_dbl_s;
    logic [NUM_CH-1:0]        req_rot_s;
    logic [CH_W-1:0]          pick_off_s;
    logic [CH_W:0]            pick_sum_s;
    logic [CH_W-1:0]          pick_ch_s;
    logic                     pick_vld_s;
    logic [NUM_CH-1:0]        req_ready_s;

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
        logic [CH_W-1:0] nxt;
        if (ch == CH_W'(NUM_CH - 1)) begin
            nxt = '0;
        end else begin
            nxt = ch + CH_W'(1);
        end
        return nxt;
    endfunction

    // Rotate requests so the pointer sits at bit 0, then take the lowest set bit.
    always_comb begin
        req_dbl_s  = {req_valid_i, req_valid_i} >> rr_ptr_r;
        req_rot_s  = req_dbl_s[NUM_CH-1:0];
        pick_off_s = '0;
        pick_vld_s = |req_rot_s;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req_rot_s[k]) begin
                pick_off_s = CH_W'(k);
            end else begin
                pick_off_s = pick_off_s;
            end
        end
        pick_sum_s = {1'b0, rr_ptr_r} + {1'b0, pick_off_s};
        if (pick_sum_s >= (CH_W+1)'(NUM_CH)) begin
            pick_ch_s = CH_W'(pick_sum_s - (CH_W+1)'(NUM_CH));
        end else begin
            pick_ch_s = CH_W'(pick_sum_s);
        end
    end

    // Next-state logic and the combinational grant.
    always_comb begin
        state_next_s = state_r;
        req_ready_s  = '0;
        case (state_r)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    state_next_s = ST_START;
                    req_ready_s  = NUM_CH'(1'b1) << pick_ch_s;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving on the last watchdog cycle still counts.
                if (cordic_done_i) begin
                    state_next_s = ST_OUTPUT;
                end else if (wdog_cnt_r == CNT_W'(TIMEOUT - 1)) begin
                    state_next_s = ST_ABORT;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_OUTPUT: begin
                if (res_ready_i) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_OUTPUT;
                end
            end
            ST_ABORT: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register plus the registered control strobes decoded from the next state.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r     <= ST_IDLE;
            start_r     <= 1'b0;
            abort_r     <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            start_r     <= (state_next_s == ST_START);
            abort_r     <= (state_next_s == ST_ABORT);
            res_valid_r <= (state_next_s == ST_OUTPUT);
        end
    end

    // Operand capture, watchdog, result capture and round-robin pointer.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rr_ptr_r   <= '0;
            grant_ch_r <= '0;
            wdog_cnt_r <= '0;
            op_sin_r   <= '0;
            op_cos_r   <= '0;
            res_phi_r  <= '0;
            res_ch_r   <= '0;
            timeout_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_vld_s) begin
                        grant_ch_r <= pick_ch_s;
                        op_sin_r   <= sin_i[pick_ch_s];
                        op_cos_r   <= cos_i[pick_ch_s];
                    end else begin
                        grant_ch_r <= grant_ch_r;
                    end
                end
                ST_START: begin
                    wdog_cnt_r <= '0;
                end
                ST_WAIT: begin
                    if (cordic_done_i) begin
                        res_phi_r <= cordic_phi_i;
                        res_ch_r  <= grant_ch_r;
                    end else begin
                        wdog_cnt_r <= wdog_cnt_r + CNT_W'(1);
                    end
                end
                ST_OUTPUT: begin
                    if (res_ready_i) begin
                        rr_ptr_r <= next_ch(grant_ch_r);
                    end else begin
                        rr_ptr_r <= rr_ptr_r;
                    end
                end
                ST_ABORT: begin
                    // The aborted sample is dropped; its channel loses this turn.
                    rr_ptr_r  <= next_ch(grant_ch_r);
                    timeout_r <= 1'b1;
                end
                default: begin
                    rr_ptr_r <= rr_ptr_r;
                end
            endcase
        end
    end

    assign req_ready_o    = reset_ni ? req_ready_s : '0;
    assign cordic_start_o = start_r;
    assign cordic_reset_o = abort_r;
    assign cordic_sin_o   = op_sin_r;
    assign cordic_cos_o   = op_cos_r;
    assign res_valid_o    = res_valid_r;
    assign res_phi_o      = res_phi_r;
    assign res_ch_o       = res_ch_r;
    assign timeout_o      = timeout_r;

endmodule
